// File: rtl/fsm_seq_driver_pkg.sv
// fsm_seq_driver shared definitions: FSM state codes,
// next-state / expected-output models and route helpers.
package fsm_seq_driver_pkg;

  localparam logic [4:0] ST_D2 = 5'b00001;
  localparam logic [4:0] ST_K4 = 5'b00010;
  localparam logic [4:0] ST_U9 = 5'b00100;
  localparam logic [4:0] ST_A2 = 5'b01000;
  localparam logic [4:0] ST_R5 = 5'b10000;

  function automatic logic [4:0] fsm_nxt(
    input logic [4:0] st,
    input logic       a5,
    input logic       i6
  );
    logic [4:0] n;
    n = ST_D2;
    case (st)
      ST_D2: n = (!a5 && !i6) ? ST_U9 : ST_A2;
      ST_K4: n = (a5 && !i6) ? ST_D2 : ST_U9;
      ST_U9: n = (!a5 && i6) ? ST_D2 : ST_U9;
      ST_A2: n = (!a5 && !i6) ? ST_D2 : ST_A2;
      ST_R5: n = (a5 && !i6) ? ST_D2 : ST_A2;
      default: n = ST_D2;
    endcase
    return n;
  endfunction

  // {u5,u8,O3,O4}
  function automatic logic [3:0] fsm_exp(
    input logic [4:0] st,
    input logic       a5,
    input logic       i6
  );
    logic [3:0] o;
    o = 4'b0000;
    case (st)
      ST_D2: o = (!a5 && !i6) ? 4'b0010 : 4'b1110;
      ST_K4: o = (!a5 || i6) ? 4'b1111 : 4'b0000;
      ST_U9: o = 4'b1000;
      ST_A2: o = (a5 || i6) ? 4'b1110 : 4'b0000;
      ST_R5: o = (!a5 || i6) ? 4'b0100 : 4'b1000;
      default: o = 4'b0000;
    endcase
    return o;
  endfunction

  // K4/R5 cannot be reached; D2 cannot be held.
  function automatic logic tgt_ok(
    input logic [4:0] st,
    input logic       hold_zero
  );
    return (st == ST_U9) || (st == ST_A2) ||
           ((st == ST_D2) && hold_zero);
  endfunction

  // {A5,I6} that moves the FSM one step toward tgt
  function automatic logic [1:0] route_pair(
    input logic [4:0] st,
    input logic [4:0] tgt
  );
    logic [1:0] p;
    p = 2'b00;
    case (st)
      ST_D2: p = (tgt == ST_A2) ? 2'b10 : 2'b00;
      ST_U9: p = 2'b01;
      ST_A2: p = 2'b00;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

  // {A5,I6} that keeps the FSM parked in tgt
  function automatic logic [1:0] hold_pair(
    input logic [4:0] tgt
  );
    return (tgt == ST_A2) ? 2'b10 : 2'b00;
  endfunction

endpackage

// File: rtl/fsm_seq_driver_if.sv
// fsm_seq_driver command interface: sequencer offers
// commands, driver answers with done / cmd_err pulses.
interface fsm_seq_driver_if #(
  parameter int HOLD_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_state;
  logic [HOLD_W-1:0] cmd_hold;
  logic              done;
  logic              cmd_err;

  modport master (
    output cmd_valid, cmd_state, cmd_hold,
    input  cmd_ready, done, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_state, cmd_hold,
    output cmd_ready, done, cmd_err
  );
endinterface

// File: rtl/fsm_shadow.sv
// fsm_shadow: shadow copy of the driven FSM plus an
// every-cycle compare of its outputs against the model.
module fsm_shadow
  import fsm_seq_driver_pkg::*;
#(
  parameter int ERRC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a5_i,
  input  logic              i6_i,
  input  logic [3:0]        out_i,
  input  logic              chk_en_i,
  output logic [4:0]        shadow_o,
  output logic [4:0]        shadow_nxt_o,
  output logic              mismatch_o,
  output logic [ERRC_W-1:0] err_cnt_o
);

  logic [4:0]        shadow_q;
  logic [4:0]        shadow_d;
  logic              miss;
  logic              mismatch_q;
  logic [ERRC_W-1:0] err_q;

  assign shadow_d = fsm_nxt(shadow_q, a5_i, i6_i);
  assign miss = chk_en_i &&
                (out_i != fsm_exp(shadow_q, a5_i, i6_i));

  // Free-running shadow; never resynced to the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= ST_D2;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (miss) begin
        mismatch_q <= 1'b1;
        if (err_q != '1)
          err_q <= err_q + 1'b1;
      end
    end
  end

  assign shadow_o     = shadow_q;
  assign shadow_nxt_o = shadow_d;
  assign mismatch_o   = mismatch_q;
  assign err_cnt_o    = err_q;

endmodule

// File: rtl/fsm_seq_driver.sv
// fsm_seq_driver: steers the 5-state FSM to a commanded
// state via registered A5/I6 and dwells there.
module fsm_seq_driver
  import fsm_seq_driver_pkg::*;
#(
  parameter int HOLD_W = 4,
  parameter int ERRC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  fsm_seq_driver_if.slave   cmd_if,
  input  logic              chk_en_i,
  output logic              A5_o,
  output logic              I6_o,
  input  logic              u5_i,
  input  logic              u8_i,
  input  logic              O3_i,
  input  logic              O4_i,
  output logic              mismatch_o,
  output logic [ERRC_W-1:0] err_cnt_o,
  output logic [4:0]        shadow_st_o
);

  localparam logic [1:0] CTL_IDLE  = 2'd0;
  localparam logic [1:0] CTL_ROUTE = 2'd1;
  localparam logic [1:0] CTL_HOLD  = 2'd2;

  logic [1:0]        ctl_q, ctl_d;
  logic [4:0]        tgt_q, tgt_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [1:0]        pin_q, pin_d;
  logic              done_q, done_d;
  logic              cerr_q, cerr_d;
  logic [4:0]        shadow_st;
  logic [4:0]        shadow_nxt;
  logic              hold_zero;

  fsm_shadow #(
    .ERRC_W(ERRC_W)
  ) u_shadow (
    .clk          (clk),
    .rst          (rst),
    .a5_i         (pin_q[1]),
    .i6_i         (pin_q[0]),
    .out_i        ({u5_i, u8_i, O3_i, O4_i}),
    .chk_en_i     (chk_en_i),
    .shadow_o     (shadow_st),
    .shadow_nxt_o (shadow_nxt),
    .mismatch_o   (mismatch_o),
    .err_cnt_o    (err_cnt_o)
  );

  assign hold_zero = (cmd_if.cmd_hold == '0);

  // Command accept, route progress and dwell countdown.
  always_comb begin
    ctl_d  = ctl_q;
    tgt_d  = tgt_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    cerr_d = 1'b0;
    unique case (1'b1)
      (ctl_q == CTL_IDLE): begin
        if (cmd_if.cmd_valid) begin
          if (!tgt_ok(cmd_if.cmd_state, hold_zero)) begin
            cerr_d = 1'b1;
          end else begin
            tgt_d = cmd_if.cmd_state;
            cnt_d = cmd_if.cmd_hold;
            if (shadow_nxt == cmd_if.cmd_state) begin
              if (hold_zero) done_d = 1'b1;
              else           ctl_d  = CTL_HOLD;
            end else begin
              ctl_d = CTL_ROUTE;
            end
          end
        end
      end
      (ctl_q == CTL_ROUTE): begin
        if (shadow_nxt == tgt_q) begin
          if (cnt_q == '0) begin
            done_d = 1'b1;
            ctl_d  = CTL_IDLE;
          end else begin
            ctl_d = CTL_HOLD;
          end
        end
      end
      (ctl_q == CTL_HOLD): begin
        if (cnt_q == HOLD_W'(1)) begin
          done_d = 1'b1;
          ctl_d  = CTL_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ctl_d = CTL_IDLE;
    endcase
  end

  // Pin pair for the cycle the control FSM enters next.
  always_comb begin
    pin_d = 2'b00;
    case (ctl_d)
      CTL_ROUTE: pin_d = route_pair(shadow_nxt, tgt_d);
      CTL_HOLD:  pin_d = hold_pair(tgt_d);
      default:   pin_d = 2'b00;
    endcase
  end

  // Control state, pins and response pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q  <= CTL_IDLE;
      tgt_q  <= ST_D2;
      cnt_q  <= '0;
      pin_q  <= 2'b00;
      done_q <= 1'b0;
      cerr_q <= 1'b0;
    end else begin
      ctl_q  <= ctl_d;
      tgt_q  <= tgt_d;
      cnt_q  <= cnt_d;
      pin_q  <= pin_d;
      done_q <= done_d;
      cerr_q <= cerr_d;
    end
  end

  assign cmd_if.cmd_ready = (ctl_q == CTL_IDLE);
  assign cmd_if.done      = done_q;
  assign cmd_if.cmd_err   = cerr_q;
  assign A5_o             = pin_q[1];
  assign I6_o             = pin_q[0];
  assign shadow_st_o      = shadow_st;

endmodule

// File: tb/tb_fsm_seq_driver.sv
// tb_fsm_seq_driver: drives commands into fsm_seq_driver
// against a bench copy of the FSM, scoreboarded responses.
module tb_fsm_seq_driver;

  localparam logic [4:0] D2 = 5'b00001;
  localparam logic [4:0] K4 = 5'b00010;
  localparam logic [4:0] U9 = 5'b00100;
  localparam logic [4:0] A2 = 5'b01000;
  localparam logic [4:0] R5 = 5'b10000;

  typedef struct {
    bit         is_err;
    logic [4:0] tgt;
    int         lat;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       chk_en;
  logic       A5, I6;
  logic       u5, u8, O3, O4;
  logic       mismatch;
  logic [7:0] err_cnt;
  logic [4:0] shadow_st;
  logic [4:0] fsm_q;
  logic       stuck_u8;
  logic [3:0] fsm_o;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  fsm_seq_driver_if #(.HOLD_W(4)) cmd_if ();

  fsm_seq_driver #(
    .HOLD_W(4),
    .ERRC_W(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_if      (cmd_if),
    .chk_en_i    (chk_en),
    .A5_o        (A5),
    .I6_o        (I6),
    .u5_i        (u5),
    .u8_i        (u8),
    .O3_i        (O3),
    .O4_i        (O4),
    .mismatch_o  (mismatch),
    .err_cnt_o   (err_cnt),
    .shadow_st_o (shadow_st)
  );

  // Bench copy of the driven FSM (rst_b = ~rst).
  always @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= D2;
    else begin
      case (fsm_q)
        D2: fsm_q <= (!A5 && !I6) ? U9 : A2;
        K4: fsm_q <= (A5 && !I6) ? D2 : U9;
        U9: fsm_q <= (!A5 && I6) ? D2 : U9;
        A2: fsm_q <= (!A5 && !I6) ? D2 : A2;
        R5: fsm_q <= (A5 && !I6) ? D2 : A2;
        default: fsm_q <= D2;
      endcase
    end
  end

  always_comb begin
    fsm_o = 4'b0000;
    case (fsm_q)
      D2: fsm_o = (!A5 && !I6) ? 4'b0010 : 4'b1110;
      K4: fsm_o = (!A5 || I6) ? 4'b1111 : 4'b0000;
      U9: fsm_o = 4'b1000;
      A2: fsm_o = (A5 || I6) ? 4'b1110 : 4'b0000;
      R5: fsm_o = (!A5 || I6) ? 4'b0100 : 4'b1000;
      default: fsm_o = 4'b0000;
    endcase
    {u5, u8, O3, O4} = fsm_o | {1'b0, stuck_u8, 2'b00};
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (cmd_if.done || cmd_if.cmd_err) begin
      chk("pulse_excl", {31'd0, cmd_if.done & cmd_if.cmd_err}, 0);
      if (sbq.size() == 0) begin
        chk("unexp_pulse", {30'd0, cmd_if.done, cmd_if.cmd_err}, 0);
      end else begin
        e = sbq.pop_front();
        chk("resp_kind", {31'd0, cmd_if.cmd_err}, {31'd0, e.is_err});
        chk("resp_lat", cyc - e.acc, e.lat);
        if (!e.is_err) chk("done_state", shadow_st, e.tgt);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    mon();
  endtask

  // lat = edges between the accept edge and the pulse edge
  task automatic send(logic [4:0] st, logic [3:0] hold,
                      bit is_err, int lat);
    exp_t e;
    chk("ready_before", {31'd0, cmd_if.cmd_ready}, 1);
    e.is_err = is_err;
    e.tgt    = st;
    e.lat    = lat;
    e.acc    = cyc + 1;
    sbq.push_back(e);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_state = st;
    cmd_if.cmd_hold  = hold;
    tick();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_state = 5'd0;
    cmd_if.cmd_hold  = 4'd0;
  endtask

  task automatic drain(int bound);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("resp_timeout", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic chk_pins(string tag, logic [1:0] exp);
    chk(tag, {30'd0, A5, I6}, {30'd0, exp});
  endtask

  initial begin
    int dn;
    rst = 1'b1;
    chk_en = 1'b1;
    stuck_u8 = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_state = 5'd0;
    cmd_if.cmd_hold  = 4'd0;
    @(negedge clk);
    @(negedge clk);

    // reset values
    chk_pins("rst_pins", 2'b00);
    chk("rst_ready", {31'd0, cmd_if.cmd_ready}, 1);
    chk("rst_done", {31'd0, cmd_if.done}, 0);
    chk("rst_cerr", {31'd0, cmd_if.cmd_err}, 0);
    chk("rst_mism", {31'd0, mismatch}, 0);
    chk("rst_errc", err_cnt, 0);
    chk("rst_shadow", shadow_st, D2);

    // 1: idle drift D2 -> U9
    rst = 1'b0;
    chk("t1_sh0", shadow_st, D2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_sh", shadow_st, U9);
      chk("t1_track", shadow_st, fsm_q);
      chk_pins("t1_pins", 2'b00);
    end
    chk("t1_mism", {31'd0, mismatch}, 0);

    // 2: U9 -> A2 via D2, done 2 edges after accept
    send(A2, 4'd0, 1'b0, 2);
    chk_pins("t2_p0", 2'b01);
    chk("t2_s0", shadow_st, U9);
    tick();
    chk_pins("t2_p1", 2'b10);
    chk("t2_s1", shadow_st, D2);
    tick();
    chk("t2_s2", shadow_st, A2);
    chk_pins("t2_p2", 2'b00);
    chk("t2_sbq", sbq.size(), 0);

    // 3: A2 -> U9 with 3 dwell cycles
    send(U9, 4'd3, 1'b0, 4);
    chk_pins("t3_p0", 2'b00);
    chk("t3_s0", shadow_st, D2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_dwell", shadow_st, U9);
      chk_pins("t3_pins", 2'b00);
      chk("t3_busy", {31'd0, cmd_if.cmd_ready}, 0);
    end
    tick();
    chk("t3_sbq", sbq.size(), 0);
    chk("t3_errc", err_cnt, 0);

    // 4: rejected commands
    send(K4, 4'd0, 1'b1, 0);
    chk("t4_rdy_k4", {31'd0, cmd_if.cmd_ready}, 1);
    send(R5, 4'd0, 1'b1, 0);
    chk("t4_rdy_r5", {31'd0, cmd_if.cmd_ready}, 1);
    send(5'b00011, 4'd0, 1'b1, 0);
    chk("t4_rdy_nh", {31'd0, cmd_if.cmd_ready}, 1);
    send(D2, 4'd2, 1'b1, 0);
    chk("t4_rdy_d2", {31'd0, cmd_if.cmd_ready}, 1);
    chk("t4_state", shadow_st, U9);
    chk("t4_sbq", sbq.size(), 0);

    // U9 -> D2 (1 route step), then U9 already current
    send(D2, 4'd0, 1'b0, 1);
    chk_pins("t4_rt", 2'b01);
    tick();
    chk("t4_d2", shadow_st, D2);
    send(U9, 4'd0, 1'b0, 0);
    chk("t4_u9", shadow_st, U9);
    drain(10);

    // 5: u8 stuck-at-1, checked then unchecked
    stuck_u8 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stuck_u8 = 1'b0;
    chk("t5_mism", {31'd0, mismatch}, 1);
    chk("t5_errc", err_cnt, 3);
    chk_en = 1'b0;
    stuck_u8 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stuck_u8 = 1'b0;
    chk_en = 1'b1;
    chk("t5_errc_off", err_cnt, 3);

    // 6: saturation, then reset mid-HOLD
    stuck_u8 = 1'b1;
    for (int i = 0; i < 252; i++) tick();
    chk("t6_sat", err_cnt, 8'hFF);
    for (int i = 0; i < 10; i++) tick();
    stuck_u8 = 1'b0;
    chk("t6_sat_hold", err_cnt, 8'hFF);

    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_state = U9;
    cmd_if.cmd_hold  = 4'd6;
    tick();
    cmd_if.cmd_state = K4;
    cmd_if.cmd_hold  = 4'd0;
    tick();
    chk("t6_busy", {31'd0, cmd_if.cmd_ready}, 0);
    chk("t6_nocerr", {31'd0, cmd_if.cmd_err}, 0);
    cmd_if.cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_pins("t6_pins", 2'b00);
    chk("t6_ready", {31'd0, cmd_if.cmd_ready}, 1);
    chk("t6_shadow", shadow_st, D2);
    chk("t6_errc", err_cnt, 0);
    chk("t6_mism", {31'd0, mismatch}, 0);
    tick();
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      dn += int'(cmd_if.done);
    end
    chk("t6_nodone", dn, 0);
    chk("t6_idle", shadow_st, U9);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
